pwm_dac: RTL and testbench

- Audio-output stage directly downstream of the NCO.
- Paces the NCO by issuing a one-cycle `next_sample` request once per PWM window.
- Captures the NCO's 10-bit `code` and renders it as a single-bit PWM waveform for the board's RC-filtered audio pin.
- Duty cycle per window = `active_code` / `CYCLES_PER_WINDOW`.

---
 rtl/pwm_dac.sv | 88 ++++++++
 tb/tb_pwm_dac.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_dac.sv
// pwm_dac: paces the upstream NCO with one sample request per PWM window,
// captures the returned code and renders it as a single-bit PWM waveform
// whose duty per window is active_code / CYCLES_PER_WINDOW.
//
// Request contract with the NCO: next_sample is a one-cycle request with no
// back-pressure. code must be valid in every cycle where next_sample is high;
// it is captured on the rising edge that ends that cycle, and the NCO
// advances on the same edge. A request issued while rst is high is dropped
// (no capture).
//
// There is no FSM here. The only sequencing state is the window counter
// (cnt), the captured duty code (active_code) and the reset-history flop.
//
// CODE_WIDTH must not exceed CNT_WIDTH: the duty compare zero-extends
// active_code to CNT_WIDTH.
module pwm_dac #(
  parameter int CODE_WIDTH        = 10,
  parameter int CYCLES_PER_WINDOW = 1024,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [CODE_WIDTH-1:0] code,
  output logic                  next_sample,
  output logic                  window_start,
  output logic                  pwm
);

  // Terminal count of the window counter.
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(CYCLES_PER_WINDOW - 1);

  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  cnt_next;
  logic [CODE_WIDTH-1:0] active_code;
  logic [CODE_WIDTH-1:0] active_code_next;
  logic [CNT_WIDTH-1:0]  active_code_ext;
  logic                  pwm_next;
  logic                  rst_q;

  // Request and window-start strobes, decoded from the current count.
  always_comb begin
    next_sample  = (cnt == LAST_CNT) && en;
    window_start = (cnt == '0) && en && !rst_q;
  end

  // Next counter value, next duty code and next PWM level.
  always_comb begin
    cnt_next         = cnt;
    active_code_next = active_code;
    pwm_next         = 1'b0;
    if (en) begin
      if (cnt == LAST_CNT) begin
        cnt_next = '0;
      end else begin
        cnt_next = cnt + CNT_WIDTH'(1);
      end
      // The capture lands exactly on the wrap, so the new duty applies
      // from cnt==0 of the next window and never mid-window.
      if (next_sample) begin
        active_code_next = code;
      end
    end
    active_code_ext = CNT_WIDTH'(active_code_next);
    // Codes at or above the window length keep pwm high all window.
    pwm_next        = en && (cnt_next < active_code_ext);
  end

  // Window state and registered PWM output; reset abandons the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      active_code <= '0;
      pwm         <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      active_code <= active_code_next;
      pwm         <= pwm_next;
    end
  end

  // Remember last cycle's reset so the first post-reset cycle is not
  // reported as a window start.
  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

endmodule

// File: tb/tb_pwm_dac.sv
// tb_pwm_dac: drives a short-window instance (8 cycles per window) with
// randomized NCO codes and an enable/reset schedule, checking every cycle
// against a window-position model, plus a per-window duty scoreboard; a
// default-size instance checks the 512/1024 duty case.
module tb_pwm_dac;

  localparam int CPW8 = 8;
  localparam int CPW1K = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8 = 1'b1;
  logic       en8 = 1'b1;
  logic [9:0] code8 = 10'd3;
  logic       ns8, ws8, pwm8;

  logic       rst1k = 1'b1;
  logic       en1k = 1'b0;
  logic [9:0] code1k = 10'd0;
  logic       ns1k, ws1k, pwm1k;

  pwm_dac #(.CODE_WIDTH(10), .CYCLES_PER_WINDOW(CPW8), .CNT_WIDTH(16)) u_dut8 (
    .clk(clk), .rst(rst8), .en(en8), .code(code8),
    .next_sample(ns8), .window_start(ws8), .pwm(pwm8)
  );

  pwm_dac u_dut1k (
    .clk(clk), .rst(rst1k), .en(en1k), .code(code1k),
    .next_sample(ns1k), .window_start(ws1k), .pwm(pwm1k)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (8-cycle instance) ----------------
  // Position inside the window, duty of the window in progress, the pwm
  // level the current cycle must show, and whether last cycle was in reset.
  int m_pos = 0;
  int m_duty = 0;
  bit m_pwm = 1'b0;
  bit m_rstq = 1'b1;
  int model_reqs = 0;
  int dut_reqs = 0;

  // Window scoreboard: expected high-cycle count of each window, in order.
  logic [31:0] exp_q[$];
  int win_high = 0;
  bit win_dirty = 1'b0;

  bit last_ns, last_pwm;

  initial exp_q.push_back(32'd0);

  // One clock cycle: check outputs mid-cycle, advance model, cross the edge.
  task automatic tick();
    bit e_ns, e_ws;
    int sat;
    #1;
    e_ns = en8 && (m_pos == CPW8 - 1);
    e_ws = en8 && (m_pos == 0) && !m_rstq;
    check_eq("next_sample", 32'(ns8), 32'(e_ns));
    check_eq("window_start", 32'(ws8), 32'(e_ws));
    check_eq("pwm", 32'(pwm8), 32'(m_pwm));
    last_ns = ns8;
    last_pwm = pwm8;
    if (ns8 === 1'b1) dut_reqs++;
    if (e_ns) model_reqs++;

    sat = (int'(code8) >= CPW8) ? CPW8 : int'(code8);
    if (rst8) begin
      exp_q.delete();
      exp_q.push_back(32'd0);
      win_high = 0;
      win_dirty = 1'b0;
    end else if (!en8) begin
      win_dirty = 1'b1;
    end else begin
      win_high += int'(pwm8);
      if (m_pos == CPW8 - 1) begin
        if (exp_q.size() > 0) begin
          if (!win_dirty) check_eq("window_high", 32'(win_high), exp_q.pop_front());
          else void'(exp_q.pop_front());
        end
        exp_q.push_back(32'(sat));
        win_high = 0;
        win_dirty = 1'b0;
      end
    end

    if (rst8) begin
      m_pos = 0;
      m_duty = 0;
      m_pwm = 1'b0;
    end else if (en8) begin
      if (e_ns) m_duty = int'(code8);
      m_pos = (m_pos + 1) % CPW8;
      m_pwm = (m_pos < m_duty);
    end else begin
      m_pwm = 1'b0;
    end
    m_rstq = rst8;
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_pos(input int pos);
    for (int i = 0; i < 2 * CPW8; i++) begin
      if (m_pos == pos) break;
      tick();
    end
    check_eq("align_pos", 32'(m_pos), 32'(pos));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] pat_pwm, pat_ns;
    int k, highs;
    @(posedge clk);
    #1;

    // Reset with code=3: window 0 silent, window 1 shows 3 high cycles.
    tick();
    rst8 = 1'b0;
    pat_pwm = '0;
    pat_ns = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      pat_pwm[i] = last_pwm;
      pat_ns[i] = last_ns;
    end
    check_eq("reset_ns_pattern", 32'(pat_ns), 32'h8080);
    check_eq("win1_pwm_pattern", 32'(pat_pwm[15:8]), 32'h07);
    check_eq("win0_pwm_pattern", 32'(pat_pwm[7:0]), 32'h00);

    // Randomized NCO codes, biased toward the saturation boundaries.
    for (int i = 0; i < 20 * CPW8; i++) begin
      case ($urandom_range(0, 5))
        0: code8 = 10'd0;
        1: code8 = 10'd7;
        2: code8 = 10'd8;
        3: code8 = 10'd1023;
        default: code8 = 10'($urandom_range(0, 1023));
      endcase
      tick();
    end

    // Saturation: full-high windows back to back, then all-high, all-low.
    code8 = 10'd8;
    for (int i = 0; i < 3 * CPW8; i++) tick();
    code8 = 10'd1023;
    for (int i = 0; i < 2 * CPW8; i++) tick();
    code8 = 10'd0;
    for (int i = 0; i < 2 * CPW8; i++) tick();

    // Enable dropped at cnt=4 for 5 cycles.
    code8 = 10'd6;
    for (int i = 0; i < 2 * CPW8; i++) tick();
    run_to_pos(4);
    en8 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("held_pos", 32'(m_pos), 32'd4);
    en8 = 1'b1;
    k = 0;
    for (int i = 0; i < 2 * CPW8; i++) begin
      k++;
      tick();
      if (last_ns) break;
    end
    check_eq("reenable_req_delay", 32'(k), 32'd4);

    // Reset landing on the request cycle: no capture, fresh window.
    code8 = 10'd5;
    for (int i = 0; i < CPW8; i++) tick();
    run_to_pos(7);
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    k = 0;
    highs = 0;
    for (int i = 0; i < 2 * CPW8; i++) begin
      k++;
      tick();
      highs += int'(last_pwm);
      if (last_ns) break;
    end
    check_eq("post_reset_req_delay", 32'(k), 32'd8);
    check_eq("post_reset_highs", 32'(highs), 32'd0);
    for (int i = 0; i < 3 * CPW8; i++) begin
      code8 = 10'($urandom_range(0, 12));
      tick();
    end
    check_eq("request_count", 32'(dut_reqs), 32'(model_reqs));

    // Default-size instance, code=512 held.
    rst8 = 1'b1;
    code1k = 10'd512;
    en1k = 1'b1;
    @(posedge clk);
    #1;
    rst1k = 1'b0;
    for (int w = 0; w < 4; w++) begin
      int wh, first_low, nsc;
      wh = 0;
      first_low = -1;
      nsc = 0;
      for (int c = 0; c < CPW1K; c++) begin
        #1;
        if (pwm1k) wh++;
        else if (first_low < 0) first_low = c;
        if (ns1k) nsc++;
        @(posedge clk);
        #1;
      end
      check_eq("w1k_requests", 32'(nsc), 32'd1);
      if (w == 0) begin
        check_eq("w1k_first_highs", 32'(wh), 32'd0);
      end else begin
        check_eq("w1k_highs", 32'(wh), 32'd512);
        check_eq("w1k_first_low", 32'(first_low), 32'd512);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
